// File: rtl/tap_tdo_ctrl.sv
// -----------------------------------------------------------------------------
// tap_tdo_ctrl
//
// JTAG return-path controller. It follows the IEEE 1149.1 TAP state machine
// from TMS and registers the serial output of either the instruction register
// or the selected data register onto TDO. It also decodes the IR/DR path
// select and the capture/shift/update strobes for the TDI-side routing and the
// register chains.
//
// Parameters
//   TDO_IDLE    value driven on TDO whenever no shift is in progress
//
// Ports
//   TCK         in   scan clock; every state change happens on its rising edge
//   Rst_n       in   synchronous active-low reset, sampled on rising TCK
//   TMS         in   TAP mode select
//   IR_Out      in   serial output bit of the instruction register
//   DR_Out      in   serial output bit of the selected data register
//   TDO         out  registered scan output
//   TDO_En      out  high while TDO carries a valid shifted bit
//   Sel         out  path select: 0 = DR, 1 = IR
//   State       out  current TAP state (standard 4-bit encoding)
//   Capture_En  out  current state is Capture-DR or Capture-IR
//   Shift_En    out  current state is Shift-DR or Shift-IR
//   Update_En   out  current state is Update-DR or Update-IR
//
// All outputs come from registers or from decode of the state register only,
// so there is no combinational path from TMS, IR_Out or DR_Out to an output.
// -----------------------------------------------------------------------------
module tap_tdo_ctrl #(
  parameter logic TDO_IDLE = 1'b0
) (
  input  logic       TCK,
  input  logic       Rst_n,
  input  logic       TMS,
  input  logic       IR_Out,
  input  logic       DR_Out,
  output logic       TDO,
  output logic       TDO_En,
  output logic       Sel,
  output logic [3:0] State,
  output logic       Capture_En,
  output logic       Shift_En,
  output logic       Update_En
);

  // The enumeration values are the conventional 1149.1 state codes; the
  // encoded value is exported directly on State.
  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TEST_RESET = 4'hF
  } tap_state_t;

  tap_state_t state_reg;
  tap_state_t state_next;
  logic       tdo_reg;
  logic       tdo_next;
  logic       tdo_en_reg;
  logic       tdo_en_next;

  // ---------------------------------------------------------------------------
  // State, TDO and TDO_En registers. Reset wins over TMS in the same cycle,
  // which also aborts any shift in progress without passing through Update.
  // ---------------------------------------------------------------------------
  always_ff @(posedge TCK) begin
    if (!Rst_n) begin
      state_reg  <= TEST_RESET;
      tdo_reg    <= TDO_IDLE;
      tdo_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tdo_reg    <= tdo_next;
      tdo_en_reg <= tdo_en_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: standard TAP transition graph.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TEST_RESET: state_next = TMS ? TEST_RESET : RUN_IDLE;
      RUN_IDLE:   state_next = TMS ? SELECT_DR  : RUN_IDLE;
      SELECT_DR:  state_next = TMS ? SELECT_IR  : CAPTURE_DR;
      SELECT_IR:  state_next = TMS ? TEST_RESET : CAPTURE_IR;

      CAPTURE_DR: state_next = TMS ? EXIT1_DR   : SHIFT_DR;
      SHIFT_DR:   state_next = TMS ? EXIT1_DR   : SHIFT_DR;
      EXIT1_DR:   state_next = TMS ? UPDATE_DR  : PAUSE_DR;
      PAUSE_DR:   state_next = TMS ? EXIT2_DR   : PAUSE_DR;
      EXIT2_DR:   state_next = TMS ? UPDATE_DR  : SHIFT_DR;
      UPDATE_DR:  state_next = TMS ? SELECT_DR  : RUN_IDLE;

      CAPTURE_IR: state_next = TMS ? EXIT1_IR   : SHIFT_IR;
      SHIFT_IR:   state_next = TMS ? EXIT1_IR   : SHIFT_IR;
      EXIT1_IR:   state_next = TMS ? UPDATE_IR  : PAUSE_IR;
      PAUSE_IR:   state_next = TMS ? EXIT2_IR   : PAUSE_IR;
      EXIT2_IR:   state_next = TMS ? UPDATE_IR  : SHIFT_IR;
      UPDATE_IR:  state_next = TMS ? SELECT_DR  : RUN_IDLE;

      default:    state_next = TEST_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TDO datapath. The bit is taken from the state held before the edge, so the
  // edge that leaves a shift state (into Exit1) still carries the last bit and
  // keeps TDO_En high; TDO_En drops on the following edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    tdo_next    = TDO_IDLE;
    tdo_en_next = 1'b0;
    case (state_reg)
      SHIFT_IR: begin
        tdo_next    = IR_Out;
        tdo_en_next = 1'b1;
      end
      SHIFT_DR: begin
        tdo_next    = DR_Out;
        tdo_en_next = 1'b1;
      end
      default: begin
        tdo_next    = TDO_IDLE;
        tdo_en_next = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decoded outputs, purely from the state register. Select-IR still belongs
  // to the DR side for routing purposes: the IR path is only selected once the
  // IR column proper (Capture-IR onward) is entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    Sel        = 1'b0;
    Capture_En = 1'b0;
    Shift_En   = 1'b0;
    Update_En  = 1'b0;
    case (state_reg)
      CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR: Sel = 1'b1;
      default:                                                        Sel = 1'b0;
    endcase
    case (state_reg)
      CAPTURE_DR, CAPTURE_IR: Capture_En = 1'b1;
      SHIFT_DR,   SHIFT_IR:   Shift_En   = 1'b1;
      UPDATE_DR,  UPDATE_IR:  Update_En  = 1'b1;
      default: begin
        Capture_En = 1'b0;
        Shift_En   = 1'b0;
        Update_En  = 1'b0;
      end
    endcase
  end

  assign State  = state_reg;
  assign TDO    = tdo_reg;
  assign TDO_En = tdo_en_reg;

endmodule

// File: tb/tb_tap_tdo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tap_tdo_ctrl
//
// Drives two instances of tap_tdo_ctrl (TDO_IDLE = 0 and TDO_IDLE = 1) with the
// same pin stimulus: directed scenarios followed by random TMS/reset/data.
// Expected values come from a table-driven reference model of the TAP graph.
// -----------------------------------------------------------------------------
module tb_tap_tdo_ctrl;

  logic       TCK = 1'b0;
  logic       Rst_n = 1'b0;
  logic       TMS = 1'b1;
  logic       IR_Out = 1'b0;
  logic       DR_Out = 1'b0;

  logic       tdo0, tdo_en0, sel0, cap0, shf0, upd0;
  logic [3:0] state0;
  logic       tdo1, tdo_en1, sel1, cap1, shf1, upd1;
  logic [3:0] state1;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [3:0] m_state;
  logic       m_tdo0, m_tdo1, m_en;

  always #5 TCK = ~TCK;

  tap_tdo_ctrl #(.TDO_IDLE(1'b0)) dut0 (
    .TCK(TCK), .Rst_n(Rst_n), .TMS(TMS), .IR_Out(IR_Out), .DR_Out(DR_Out),
    .TDO(tdo0), .TDO_En(tdo_en0), .Sel(sel0), .State(state0),
    .Capture_En(cap0), .Shift_En(shf0), .Update_En(upd0)
  );

  tap_tdo_ctrl #(.TDO_IDLE(1'b1)) dut1 (
    .TCK(TCK), .Rst_n(Rst_n), .TMS(TMS), .IR_Out(IR_Out), .DR_Out(DR_Out),
    .TDO(tdo1), .TDO_En(tdo_en1), .Sel(sel1), .State(state1),
    .Capture_En(cap1), .Shift_En(shf1), .Update_En(upd1)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic in_ir_column(input logic [3:0] s);
    return (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
           (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
  endfunction

  // One TCK cycle: drive pins mid-low-phase, advance the model at the edge,
  // then compare both instances shortly after the edge.
  task automatic step(input logic rst_n, input logic tms, input logic ir, input logic dr);
    logic [3:0] s;
    @(negedge TCK);
    Rst_n = rst_n; TMS = tms; IR_Out = ir; DR_Out = dr;
    @(posedge TCK);
    s = m_state;
    if (!rst_n) begin
      m_state = 4'hF; m_tdo0 = 1'b0; m_tdo1 = 1'b1; m_en = 1'b0;
    end else begin
      m_en    = (s == 4'h2) || (s == 4'hA);
      m_tdo0  = (s == 4'hA) ? ir : (s == 4'h2) ? dr : 1'b0;
      m_tdo1  = (s == 4'hA) ? ir : (s == 4'h2) ? dr : 1'b1;
      m_state = tms ? nx1[s] : nx0[s];
    end
    #1;
    check("state0",  state0,      m_state);
    check("state1",  state1,      m_state);
    check("tdo0",    4'(tdo0),    4'(m_tdo0));
    check("tdo1",    4'(tdo1),    4'(m_tdo1));
    check("tdo_en0", 4'(tdo_en0), 4'(m_en));
    check("tdo_en1", 4'(tdo_en1), 4'(m_en));
    check("sel0",    4'(sel0),    4'(in_ir_column(m_state)));
    check("sel1",    4'(sel1),    4'(in_ir_column(m_state)));
    check("capture", 4'(cap0),    4'((m_state == 4'h6) || (m_state == 4'hE)));
    check("shift",   4'(shf0),    4'((m_state == 4'h2) || (m_state == 4'hA)));
    check("update",  4'(upd0),    4'((m_state == 4'h5) || (m_state == 4'hD)));
    check("strb1",   {1'b0, cap1, shf1, upd1}, {1'b0, cap0, shf0, upd0});
  endtask

  initial begin
    logic [3:0] tlr_seq [5];
    logic       ir_bits [4];
    logic       tms_b;
    logic       rst_b;
    // Transition graph, indexed by state code.
    nx0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nx1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    tlr_seq = '{4'h9, 4'hD, 4'h7, 4'h4, 4'hF};
    ir_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    m_state = 4'hF; m_tdo0 = 1'b0; m_tdo1 = 1'b1; m_en = 1'b0;

    // Reset while shifting DR with DR_Out=1
    step(0, 1, 0, 0);
    check("rst_init_state", state0, 4'hF);
    check("rst_init_tdo1", 4'(tdo1), 4'h1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 1);
    check("in_shift_dr", state0, 4'h2);
    step(0, 0, 0, 1);
    check("rst_mid_state", state0, 4'hF);
    check("rst_mid_tdo", 4'(tdo0), 4'h0);
    check("rst_mid_en", 4'(tdo_en0), 4'h0);
    check("rst_mid_shift", 4'(shf0), 4'h0);

    // TLR escape from Shift-IR
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    check("in_shift_ir", state0, 4'hA);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      check("tlr_escape", state0, tlr_seq[i]);
    end

    // IR shift of 1,0,1,1
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    check("sel_cap_ir", 4'(sel0), 4'h1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, (i == 3), ir_bits[i], 0);
      check("ir_shift_tdo", 4'(tdo0), 4'(ir_bits[i]));
      check("ir_shift_en", 4'(tdo_en0), 4'h1);
    end
    step(1, 1, 1, 0);
    check("ir_done_en", 4'(tdo_en0), 4'h0);
    check("ir_update", {2'b0, sel0, upd0}, 4'h3);
    step(1, 0, 0, 0);
    check("ir_back_idle", state0, 4'hC);

    // DR shift with pause, then resume through Exit2
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 1);
    step(1, 1, 0, 0); check("dr_exit1", state0, 4'h1);
    step(1, 0, 0, 0); check("dr_pause", state0, 4'h3);
    check("pause_idle_tdo1", 4'(tdo1), 4'h1);
    step(1, 0, 0, 0); check("dr_pause_hold", state0, 4'h3);
    check("pause_en", 4'(tdo_en0), 4'h0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); check("dr_resume", state0, 4'h2);
    step(1, 0, 0, 1); check("dr_resume_tdo", 4'(tdo0), 4'h1);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    check("dr_update", {2'b0, sel0, upd0}, 4'h1);
    step(1, 0, 0, 0);
    check("dr_back_idle", state0, 4'hC);
    check("dr_upd_once", 4'(upd0), 4'h0);

    // Random traffic, TMS biased low so shift/pause states are visited often
    for (int n = 0; n < 2000; n++) begin
      tms_b = ($urandom_range(0, 99) < 35);
      rst_b = ($urandom_range(0, 99) >= 2);
      step(rst_b, tms_b, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/tap_tdo_ctrl.md
# tap_tdo_ctrl

JTAG return-path controller: tracks the IEEE 1149.1 TAP state from TMS and steers the IR or DR serial output onto a registered TDO. It also drives the IR/DR select and the capture/shift/update strobes consumed by the TDI-side routing and the instruction and data registers. It sits between the TAP pins and the register chains, closing the scan loop that the TDI-side demultiplexing opens.

## Interface
- TDO_IDLE, default 1'b0: TDO value driven whenever not shifting.

- TCK  input  1  scan clock; all state changes on rising edge
- Rst_n  input  1  synchronous, active-low reset; sampled on rising TCK
- TMS  input  1  TAP mode select
- IR_Out  input  1  serial output bit of instruction register
- DR_Out  input  1  serial output bit of selected data register
- TDO  output reg  1  registered scan output
- TDO_En  output reg  1  high when TDO carries valid shifted data
- Sel  output  1  0 = DR path, 1 = IR path; drives TDI-side routing
- State  output  4  current TAP state encoding
- Capture_En, Shift_En, Update_En  output  1 each  decoded strobes for the current state (apply to the path given by Sel)

## Operation
- State encoding (hex): Test-Logic-Reset F, Run-Test/Idle C, Select-DR 7, Capture-DR 6, Shift-DR 2, Exit1-DR 1, Pause-DR 3, Exit2-DR 0, Update-DR 5, Select-IR 4, Capture-IR E, Shift-IR A, Exit1-IR 9, Pause-IR B, Exit2-IR 8, Update-IR D.
- Transitions (TMS=0 / TMS=1):
  - F→C/F; C→C/7; 7→6/4; 4→E/F.
  - 6→2/1; 2→2/1; 1→3/5; 3→3/0; 0→2/5; 5→C/7.
  - E→A/9; A→A/9; 9→B/D; B→B/8; 8→A/D; D→C/7.
- Five consecutive TMS=1 reach F from any state.
- Sel = 1 in states E, A, 9, B, 8, D; 0 in all others, including 4. Combinational from State.
- Strobes, combinational from State:
  - Capture_En in 6 or E.
  - Shift_En in 2 or A.
  - Update_En in 5 or D.
- TDO register, updated each rising TCK from the state held before the edge:
  - State A: TDO ← IR_Out.
  - State 2: TDO ← DR_Out.
  - Otherwise: TDO ← TDO_IDLE.
- TDO_En register, updated each rising TCK: 1 if the state held before the edge was 2 or A, else 0.
- Reset, with Rst_n low at a rising edge and regardless of TMS: State=F, TDO=TDO_IDLE, TDO_En=0. Sel=0 and all strobes are 0 as a consequence of State=F.
- Rst_n overrides TMS in the same cycle. Reset mid-shift aborts the shift; no Update strobe is produced.

## Timing
- State latency: one TCK edge from TMS sample to new State.
- TDO/TDO_En latency: one edge after the shift state is present. The first valid bit appears on the edge that leaves the first shift cycle.
- On the edge that moves Shift→Exit1, TDO still takes the last IR_Out/DR_Out bit and TDO_En is 1. TDO_En returns to 0 one edge later.
- Pause states hold indefinitely with TMS=0. TDO=TDO_IDLE and TDO_En=0 while paused. Shifting resumes through Exit2→Shift.
- Strobes and Sel change in the same cycle as State; no added latency.
- No combinational path from TMS, IR_Out or DR_Out to any output.

## Test plan
- Reset: drive Rst_n=0 for one edge while in state 2 with DR_Out=1. Required: State=F, TDO=0, TDO_En=0, Shift_En=0 after that edge.
- TLR escape: from state A, TMS=1 for 5 edges. Required: State sequence 9, D, 7, 4, F.
- IR shift: from F, TMS 0,1,1,0,0. Required: State C, 7, 4, E, A; Sel=1 from E. Then TMS=0,0,0,1 with IR_Out=1,0,1,1. Required: TDO=1,0,1,1 on the next four edges, TDO_En=1 for those four edges, then 0.
- DR shift with pause: enter state 2 with DR_Out=0,1, then TMS=1,0,0. Required: State goes 1, 3, 3. TDO=TDO_IDLE and TDO_En=0 from the second edge after leaving 2. Then TMS=1,0 gives 0→2, and shifting resumes with TDO following DR_Out.
- Update strobes: the Exit1-DR→Update-DR path gives exactly one Update_En cycle with Sel=0; the IR equivalent gives Update_En with Sel=1. Both paths then return to C with TMS=0.
- Parameter: with TDO_IDLE=1, TDO=1 after reset and in every non-shift state.
